// File: rtl/counter_pkg.sv
// counter_pkg: shared widths and the prescaler terminal-value helper
package counter_pkg;
  localparam int COUNT_W = 16;
  localparam int PRESCALE_W = 8;
  localparam int PSC_W = 16;
  localparam int MAX_EXP = 16;
  // T = 2^min(p,16) - 1; a shift by 16 clears the mask, giving all ones
  function automatic logic [PSC_W-1:0] term_val(input logic [PRESCALE_W-1:0] p);
    logic [4:0] e;
    e = (p > PRESCALE_W'(MAX_EXP)) ? 5'(MAX_EXP) : p[4:0];
    return ~({PSC_W{1'b1}} << e);
  endfunction
endpackage

// File: rtl/counter_if.sv
// counter_if: control inputs and count output of the PWM timebase
// master drives en/count_reset/period/prescale/upnotdown and reads count_val; slave is the counter
interface counter_if;
  import counter_pkg::*;
  logic en;
  logic count_reset;
  logic [COUNT_W-1:0] period;
  logic [PRESCALE_W-1:0] prescale;
  logic upnotdown;
  logic [COUNT_W-1:0] count_val;
  modport master (output en, count_reset, period, prescale, upnotdown, input count_val);
  modport slave (input en, count_reset, period, prescale, upnotdown, output count_val);
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: 2^min(exp,16) divider with up/down phase, emits a one-cycle tick
// ports: clk, rst (sync), en (hold when low), clear (sync restart), exp (divider exponent),
//        upnotdown (1 = count up), tick (combinational pulse, valid only while enabled)
module counter_prescaler
  import counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] exp,
  input  logic                  upnotdown,
  output logic                  tick
);
  logic [PSC_W-1:0] psc_q, psc_d, t;
  always_comb begin
    t = term_val(exp);
    psc_d = psc_q;
    tick = 1'b0;
    if (rst || clear) begin
      psc_d = upnotdown ? '0 : t;
    end else if (en && upnotdown) begin
      tick = psc_q >= t;
      psc_d = tick ? '0 : psc_q + 1'b1;
    end else if (en) begin
      // a phase above T (exponent just reduced) is pulled back to T without a tick
      tick = psc_q == '0;
      psc_d = (tick || psc_q > t) ? t : psc_q - 1'b1;
    end
  end
  always_ff @(posedge clk) psc_q <= psc_d;
endmodule

// File: rtl/counter.sv
// counter: prescaled 16-bit wrapping up-counter, timebase of the PWM generator
// ports: clk, rst (sync, active high), bus (counter_if.slave: en, count_reset, period,
//        prescale, upnotdown in; registered count_val out)
module counter
  import counter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  counter_if.slave bus
);
  logic [COUNT_W-1:0] count_q, count_d;
  logic tick;
  counter_prescaler u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .clear     (bus.count_reset),
    .exp       (bus.prescale),
    .upnotdown (bus.upnotdown),
    .tick      (tick)
  );
  // >= rather than == so a period lowered below the count wraps on the next tick
  always_comb count_d = (rst || bus.count_reset) ? '0 :
                        !tick ? count_q :
                        (count_q >= bus.period) ? '0 : count_q + 1'b1;
  always_ff @(posedge clk) count_q <= count_d;
  assign bus.count_val = count_q;
endmodule

// File: tb/tb_counter.sv
// tb_counter: table vectors, directed corner sequences and randomized run against a reference model
module tb_counter;
  typedef struct {
    logic        en;
    logic        cr;
    logic [15:0] period;
    logic [7:0]  presc;
    logic        up;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic cr = 1'b0;
  logic [15:0] period = '0;
  logic [7:0] presc = '0;
  logic up = 1'b1;
  logic [15:0] count_val;
  int checks = 0;
  int errors = 0;
  int m_k = 0;
  logic [15:0] m_c = '0;
  vec_t vecs [13];

  always #5 clk = ~clk;

  counter_if bus ();
  assign bus.en = en;
  assign bus.count_reset = cr;
  assign bus.period = period;
  assign bus.prescale = presc;
  assign bus.upnotdown = up;
  assign count_val = bus.count_val;

  counter dut (.clk(clk), .rst(rst), .bus(bus));

  // model: count enabled edges since the last restart; every 2^e-th one is a tick
  task automatic step();
    int e;
    @(posedge clk);
    e = (presc > 8'd16) ? 16 : int'(presc);
    if (rst || cr) begin
      m_k = 0;
      m_c = '0;
    end else if (en) begin
      m_k++;
      if (m_k % (1 << e) == 0) m_c = (m_c >= period) ? 16'd0 : m_c + 16'd1;
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] exp);
    checks++;
    if (count_val !== exp) begin
      errors++;
      $display("FAIL %s: count_val=%0d expected %0d", nm, count_val, exp);
    end
  endtask

  task automatic restart();
    cr = 1'b1;
    en = 1'b0;
    step();
    chk("restart", 16'd0);
    cr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'd2, 8'd1, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 16'd3, 8'd0, 1'b1, 16'd0};
    vecs[8]  = '{1'b1, 1'b0, 16'd3, 8'd0, 1'b1, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 16'd3, 8'd0, 1'b1, 16'd2};
    vecs[10] = '{1'b1, 1'b0, 16'd3, 8'd0, 1'b1, 16'd3};
    vecs[11] = '{1'b1, 1'b0, 16'd3, 8'd0, 1'b1, 16'd0};
    vecs[12] = '{1'b1, 1'b0, 16'd3, 8'd0, 1'b1, 16'd1};

    repeat (2) begin
      step();
      chk("reset", 16'd0);
    end
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("idle_after_reset", 16'd0);
    end

    presc = 8'd2;
    period = 16'd5;
    up = 1'b1;
    restart();
    en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 3) chk("psc2_edge3", 16'd0);
      if (i == 4) chk("psc2_edge4", 16'd1);
      if (i == 8) chk("psc2_edge8", 16'd2);
      if (i == 20) chk("psc2_edge20", 16'd5);
      if (i == 23) chk("psc2_edge23", 16'd5);
      if (i == 24) chk("psc2_wrap", 16'd0);
    end

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en;
      cr = vecs[i].cr;
      period = vecs[i].period;
      presc = vecs[i].presc;
      up = vecs[i].up;
      step();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end
    cr = 1'b0;

    presc = 8'd2;
    period = 16'd7;
    up = 1'b0;
    restart();
    en = 1'b1;
    repeat (6) step();
    chk("gate_pre", 16'd1);
    en = 1'b0;
    repeat (3) begin
      step();
      chk("gate_hold", 16'd1);
    end
    en = 1'b1;
    step();
    chk("gate_resume1", 16'd1);
    step();
    chk("gate_resume2", 16'd2);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("gate_next", (i == 4) ? 16'd3 : 16'd2);
    end

    presc = 8'd0;
    period = 16'd5;
    up = 1'b1;
    restart();
    en = 1'b1;
    repeat (4) step();
    chk("lower_pre", 16'd4);
    period = 16'd2;
    step();
    chk("lower_wrap", 16'd0);
    step();
    chk("lower_after", 16'd1);

    period = 16'd0;
    restart();
    en = 1'b1;
    repeat (6) begin
      step();
      chk("period0", 16'd0);
    end

    for (int s = 0; s < 20; s++) begin
      presc = 8'($urandom_range(0, 3));
      up = 1'($urandom_range(0, 1));
      period = 16'($urandom_range(0, 7));
      restart();
      for (int i = 0; i < 60; i++) begin
        en = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 7) == 0) period = 16'($urandom_range(0, 7));
        step();
        chk("random", m_c);
      end
      rst = 1'b0;
    end

    presc = 8'd200;
    period = 16'd9;
    up = 1'b1;
    restart();
    en = 1'b1;
    repeat (65535) step();
    chk("psc200_edge65535", 16'd0);
    step();
    chk("psc200_edge65536", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
